// File: rtl/jt12_pkg.sv
// Shared jt12 definitions: mixer state encoding and accumulator/saturation width helpers.
package jt12_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } mix_state_e;

  // Sum of NCH signed x unsigned products: product is w+gw+1 bits, plus log2 growth.
  function automatic int mix_acc_w(input int nch, input int w, input int gw);
    return w + gw + 1 + $clog2(nch);
  endfunction

  // Width feeding the saturator once the fractional gain bits are dropped.
  function automatic int mix_sat_in_w(input int nch, input int w, input int gw, input int frac);
    return mix_acc_w(nch, w, gw) - frac;
  endfunction

endpackage

// File: rtl/jt12_sat_w.sv
// Signed saturation from WI bits down to WO bits (clamps to the WO-bit two's complement range).
module jt12_sat_w #(
  parameter int WI = 23,
  parameter int WO = 16
) (
  input  logic signed [WI-1:0] din,
  output logic signed [WO-1:0] dout
);

  generate
    if (WI > WO) begin : g_sat
      logic hi_ones;
      logic hi_zeros;

      // In range only when every bit above the output sign matches it.
      assign hi_ones  = &din[WI-1:WO-1];
      assign hi_zeros = ~|din[WI-1:WO-1];

      always_comb begin
        if (hi_ones || hi_zeros) begin
          dout = din[WO-1:0];
        end else if (din[WI-1]) begin
          dout = {1'b1, {(WO-1){1'b0}}};
        end else begin
          dout = {1'b0, {(WO-1){1'b1}}};
        end
      end
    end else begin : g_ext
      assign dout = WO'(din);
    end
  endgenerate

endmodule

// File: rtl/jt12_snd_mix.sv
// Gain-weighted channel mixer: latches all channels on a strobe, then accumulates one
// channel per cen edge through a single shared multiplier and emits a saturated mix.
module jt12_snd_mix
  import jt12_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int W    = 16,
  parameter int GW   = 8,
  parameter int FRAC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic                  snd_sample,
  input  logic [NCH*W-1:0]      ch_snd,
  input  logic [NCH*GW-1:0]     ch_gain,
  output logic signed [W-1:0]   mix,
  output logic                  mix_sample,
  output logic                  busy,
  output logic                  overrun
);

  localparam int AW = mix_acc_w(NCH, W, GW);
  localparam int PW = W + GW + 1;
  localparam int CW = $clog2(NCH);

  mix_state_e         state_q, state_d;
  logic [NCH*W-1:0]   snd_q, snd_d;
  logic [NCH*GW-1:0]  gain_q, gain_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [W-1:0] mix_q, mix_d;
  logic               mix_sample_q, mix_sample_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic signed [W-1:0]  cur_snd;
  logic [GW-1:0]        cur_gain;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_shift;
  logic signed [W-1:0]  sat_out;

  // The one multiplier, steered by the channel counter.
  always_comb begin
    cur_snd  = snd_q[int'(cnt_q)*W +: W];
    cur_gain = gain_q[int'(cnt_q)*GW +: GW];
    prod     = PW'(cur_snd) * $signed({1'b0, cur_gain});
  end

  assign acc_shift = acc_q >>> FRAC;

  jt12_sat_w #(
    .WI (AW),
    .WO (W)
  ) u_sat (
    .din  (acc_shift),
    .dout (sat_out)
  );

  always_comb begin
    state_d      = state_q;
    snd_d        = snd_q;
    gain_d       = gain_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    mix_d        = mix_q;
    mix_sample_d = mix_sample_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    if (cen) begin
      mix_sample_d = 1'b0;
      if (snd_sample && state_q != IDLE) begin
        overrun_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (snd_sample) begin
            snd_d   = ch_snd;
            gain_d  = ch_gain;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ACC;
          end
        end
        ACC: begin
          acc_d = acc_q + AW'(prod);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(NCH - 1)) begin
            cnt_d   = '0;
            state_d = OUT;
          end
        end
        OUT: begin
          mix_d        = sat_out;
          mix_sample_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      snd_q        <= '0;
      gain_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      mix_q        <= '0;
      mix_sample_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      snd_q        <= snd_d;
      gain_q       <= gain_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      mix_q        <= mix_d;
      mix_sample_q <= mix_sample_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mix        = mix_q;
  assign mix_sample = mix_sample_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_jt12_snd_mix.sv
// Self-checking bench for jt12_snd_mix: per-cycle comparison against a schedule-level model
// plus directed vectors with literal expected mixes and timings.
module tb_jt12_snd_mix;

  localparam int NCH  = 4;
  localparam int W    = 16;
  localparam int GW   = 8;
  localparam int FRAC = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cen = 1'b1;
  logic                snd_sample = 1'b0;
  logic [NCH*W-1:0]    ch_snd = '0;
  logic [NCH*GW-1:0]   ch_gain = '0;
  logic signed [W-1:0] mix;
  logic                mix_sample;
  logic                busy;
  logic                overrun;

  int total = 0;
  int bad   = 0;

  jt12_snd_mix #(.NCH(NCH), .W(W), .GW(GW), .FRAC(FRAC)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .snd_sample (snd_sample),
    .ch_snd     (ch_snd),
    .ch_gain    (ch_gain),
    .mix        (mix),
    .mix_sample (mix_sample),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference mix: exact integer sum, floor division by 2^FRAC, clamp.
  function automatic longint ref_mix(input logic [NCH*W-1:0] s, input logic [NCH*GW-1:0] g);
    longint sum;
    logic signed [W-1:0] sv;
    sum = 0;
    for (int i = 0; i < NCH; i++) begin
      sv  = s[i*W +: W];
      sum = sum + longint'(sv) * longint'(g[i*GW +: GW]);
    end
    sum = sum >>> FRAC;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  // Model: a strobe in idle schedules a result NCH+1 cen edges later.
  int     remain = 0;
  longint pend_mix = 0;
  longint exp_mix = 0;
  logic   exp_ms = 1'b0;
  logic   exp_busy = 1'b0;
  logic   exp_ovr = 1'b0;
  logic   chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      remain = 0; exp_mix = 0; exp_ms = 0; exp_busy = 0; exp_ovr = 0;
      chk_en = 1'b1;
    end else if (cen) begin
      exp_ms = 1'b0;
      if (remain > 0) begin
        if (snd_sample) exp_ovr = 1'b1;
        remain = remain - 1;
        if (remain == 0) begin
          exp_mix  = pend_mix;
          exp_ms   = 1'b1;
          exp_busy = 1'b0;
        end
      end else if (snd_sample) begin
        pend_mix = ref_mix(ch_snd, ch_gain);
        remain   = NCH + 1;
        exp_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (longint'(mix) != exp_mix) begin
        bad++; $display("FAIL cyc_mix t=%0t got=%0d want=%0d", $time, mix, exp_mix);
      end
      total++;
      if (mix_sample !== exp_ms) begin
        bad++; $display("FAIL cyc_mix_sample t=%0t got=%b want=%b", $time, mix_sample, exp_ms);
      end
      total++;
      if (busy !== exp_busy) begin
        bad++; $display("FAIL cyc_busy t=%0t got=%b want=%b", $time, busy, exp_busy);
      end
      total++;
      if (overrun !== exp_ovr) begin
        bad++; $display("FAIL cyc_overrun t=%0t got=%b want=%b", $time, overrun, exp_ovr);
      end
    end
  end

  task automatic check_val(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++; $display("FAIL %s got=%0d want=%0d", name, act, want);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic set_vec(input int c0, input int c1, input int c2, input int c3, input int g);
    ch_snd[0*W +: W] = W'(c0);
    ch_snd[1*W +: W] = W'(c1);
    ch_snd[2*W +: W] = W'(c2);
    ch_snd[3*W +: W] = W'(c3);
    for (int i = 0; i < NCH; i++) ch_gain[i*GW +: GW] = GW'(g);
  endtask

  // Strobe at the current negedge, then count negedges until mix_sample; returns -1 on timeout.
  task automatic run_mix(output int n, output int busy_cnt);
    n = -1;
    busy_cnt = 0;
    snd_sample = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      snd_sample = 1'b0;
      if (busy) busy_cnt++;
      if (mix_sample) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      total++; bad++;
      $display("FAIL run_mix_timeout got=no_pulse want=pulse");
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  int n, bc, edges;

  initial begin
    rst = 1'b1; cen = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset_mix", mix, 0);
    check_val("reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Unity gain
    set_vec(1000, 2000, -500, 0, 16);
    run_mix(n, bc);
    check_val("unity_mix", mix, 2500);
    check_val("unity_latency", n, 6);
    check_val("unity_busy_cycles", bc, 5);
    check_val("model_unity", ref_mix(ch_snd, ch_gain), 2500);
    repeat (2) @(negedge clk);
    check_val("unity_hold", mix, 2500);

    // Saturation
    set_vec(30000, 30000, 30000, 30000, 32);
    run_mix(n, bc);
    check_val("sat_pos", mix, 32767);
    @(negedge clk);
    set_vec(-30000, -30000, -30000, -30000, 32);
    run_mix(n, bc);
    check_val("sat_neg", mix, -32768);
    @(negedge clk);

    // Floor rounding
    set_vec(1001, 0, 0, 0, 0);
    ch_gain[0 +: GW] = 8'h08;
    run_mix(n, bc);
    check_val("round_pos", mix, 500);
    @(negedge clk);
    ch_snd[0 +: W] = W'(-1001);
    run_mix(n, bc);
    check_val("round_neg", mix, -501);
    @(negedge clk);

    // Overrun: second strobe two edges in, with different data
    set_vec(1000, 2000, -500, 0, 16);
    snd_sample = 1'b1;
    @(negedge clk); snd_sample = 1'b0;
    @(negedge clk);
    set_vec(7, 7, 7, 7, 200);
    snd_sample = 1'b1;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      snd_sample = 1'b0;
      if (mix_sample) begin n = i; break; end
    end
    check_val("ovr_mix", mix, 2500);
    check_val("ovr_flag", overrun, 1);
    repeat (3) @(negedge clk);
    check_val("ovr_sticky", overrun, 1);
    do_reset();
    check_val("ovr_cleared", overrun, 0);

    // Strobe coinciding with the OUT edge counts as busy
    set_vec(100, 100, 100, 100, 16);
    snd_sample = 1'b1;
    @(negedge clk); snd_sample = 1'b0;
    repeat (4) @(negedge clk);
    snd_sample = 1'b1;
    @(negedge clk); snd_sample = 1'b0;
    check_val("out_edge_pulse", mix_sample, 1);
    check_val("out_edge_ovr", overrun, 1);
    check_val("out_edge_busy", busy, 0);
    do_reset();

    // cen stall
    set_vec(1000, 2000, -500, 0, 16);
    cen = 1'b1;
    snd_sample = 1'b1;
    edges = 0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      edges += int'(cen);
      if (mix_sample) begin n = i; break; end
      cen = ~cen;
      snd_sample = 1'b0;
    end
    check_val("stall_mix", mix, 2500);
    check_val("stall_cen_edges", edges, 6);
    cen = 1'b0;
    @(negedge clk);
    check_val("stall_ms_held", mix_sample, 1);
    cen = 1'b1;
    @(negedge clk);
    check_val("stall_ms_clear", mix_sample, 0);

    // Reset during ACC
    do_reset();
    set_vec(1000, 2000, -500, 0, 16);
    snd_sample = 1'b1;
    @(negedge clk); snd_sample = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_acc_mix", mix, 0);
    check_val("rst_acc_busy", busy, 0);
    bc = 0;
    repeat (8) begin
      @(negedge clk);
      if (mix_sample) bc++;
    end
    check_val("rst_acc_no_pulse", bc, 0);
    set_vec(1001, 0, 0, 0, 0);
    ch_gain[0 +: GW] = 8'h08;
    run_mix(n, bc);
    check_val("rst_then_mix", mix, 500);
    check_val("rst_then_latency", n, 6);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jt12_snd_mix.md
JT12_SND_MIX -- requirements
Module: jt12_snd_mix

Interface
REQ-001 Parameter NCH, default 4, number of mixed channels, legal range 2..8.
REQ-002 Parameter W, default 16, signed sample width for inputs and output.
REQ-003 Parameter GW, default 8, unsigned per-channel gain width.
REQ-004 Parameter FRAC, default 4, fractional bits of gain; gain value 2^FRAC is unity.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cen  input  1  clock enable; state advances only on edges with cen=1.
REQ-008 snd_sample  input  1  new-sample strobe, sampled only when cen=1.
REQ-009 ch_snd  input  NCH*W  signed channel samples; channel i occupies bits [i*W +: W].
REQ-010 ch_gain  input  NCH*GW  unsigned gains; channel i occupies bits [i*GW +: GW].
REQ-011 mix  output  W  signed saturated mix, registered.
REQ-012 mix_sample  output  1  one-cen-cycle pulse marking a new mix value.
REQ-013 busy  output  1  high while a mix is in progress.
REQ-014 overrun  output  1  sticky flag, set when a strobe arrives while busy.

Function
REQ-015 The block SHALL use states IDLE, ACC and OUT.
REQ-016 In IDLE, a cen edge with snd_sample=1 SHALL latch all ch_snd and ch_gain, clear the accumulator and channel counter, and enter ACC.
REQ-017 In ACC, each cen edge SHALL add ch_snd[i]*ch_gain[i] (signed x unsigned, W+GW+1 bits) to the accumulator and increment i.
REQ-018 The accumulator SHALL be W+GW+1+clog2(NCH) bits wide and never wrap.
REQ-019 After channel NCH-1 is added, the state SHALL become OUT.
REQ-020 In OUT, the block SHALL load mix with the accumulator arithmetically shifted right by FRAC (floor), saturated to [-2^(W-1), 2^(W-1)-1], then return to IDLE.
REQ-021 mix_sample SHALL be high exactly for the cen cycle following the OUT edge, i.e. on edge k+NCH+1 after strobe edge k, counted in cen edges; low otherwise.
REQ-022 mix SHALL hold its value between updates.
REQ-023 busy SHALL be high in ACC and OUT and low in IDLE.
REQ-024 A strobe while busy SHALL be ignored for data and SHALL set overrun; the mix in progress completes unaltered.
REQ-025 A strobe on the same cen edge as the return to IDLE (OUT edge) SHALL count as busy (ignored, overrun set).
REQ-026 Edges with cen=0 SHALL change no state; mix_sample SHALL remain asserted until the next cen edge.
REQ-027 Input changes after latching SHALL not affect the mix in progress.

Reset
REQ-028 While rst=1, on each clk edge: state=IDLE, mix=0, mix_sample=0, busy=0, overrun=0, accumulator and counter=0, regardless of cen.
REQ-029 Reset mid-ACC or mid-OUT SHALL abort the mix with no mix_sample pulse.

Structure
REQ-030 State encoding and the saturation width helper SHALL reside in the shared jt12 package.
REQ-031 Saturation SHALL be a sub-module, jt12_sat_w, parameterised on input and output widths.
REQ-032 One multiplier SHALL be time-shared across channels.

Verification
(NCH=4, W=16, GW=8, FRAC=4, cen=1 unless stated.)
REQ-033 Unity: gains all 0x10, ch=1000,2000,-500,0, strobe -> mix=2500, mix_sample pulse 5 edges after strobe edge, busy high 5 edges.
REQ-034 Saturation: all ch=30000 gain 0x20 -> mix=32767; all ch=-30000 gain 0x20 -> mix=-32768.
REQ-035 Rounding: ch0=1001 gain 0x08, others 0 -> mix=500; ch0=-1001 -> mix=-501.
REQ-036 Overrun: second strobe 2 edges after first with different data -> result from first data only, overrun=1 until rst.
REQ-037 cen stall: cen toggling 1,0,1,0 with unity vector -> mix=2500 after 5 cen edges; mix_sample held across cen=0 cycles.
REQ-038 Reset: rst asserted during ACC (third edge) -> mix=0, busy=0, no mix_sample; next strobe mixes normally.
